// File: rtl/sr.sv
// sr: 8-bit accumulating result register for the CPU datapath.
// One ALU operation on (R, Dsrin) is captured per enabled clock edge.
module sr (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ISUMn,
  input  logic       ISUBn,
  input  logic       IMULn,
  input  logic       IDIVn,
  input  logic       ISHLn,
  input  logic       ISHRn,
  input  logic       ESRn,
  input  logic [7:0] Dsrin,
  output logic [7:0] Dout
);

  typedef enum logic [2:0] {
    OP_LD,
    OP_SUM,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_SHL,
    OP_SHR
  } op_e;

  logic [7:0] r_acc;
  op_e        w_op;
  logic [7:0] w_sum;
  logic [7:0] w_sub;
  logic [7:0] w_mul;
  logic [7:0] w_div;
  logic [7:0] w_shl;
  logic [7:0] w_shr;
  logic [7:0] w_next;
  logic [8:0] w_rem;

  // Several strobes may be low at once; earlier ones win.
  always_comb begin
    w_op = OP_LD;
    priority case (1'b1)
      !ISUMn: w_op = OP_SUM;
      !ISUBn: w_op = OP_SUB;
      !IMULn: w_op = OP_MUL;
      !IDIVn: w_op = OP_DIV;
      !ISHLn: w_op = OP_SHL;
      !ISHRn: w_op = OP_SHR;
      default: w_op = OP_LD;
    endcase
  end

  assign w_sum = r_acc + Dsrin;
  assign w_sub = r_acc - Dsrin;
  assign w_mul = r_acc * Dsrin;
  assign w_shl = r_acc << Dsrin[2:0];
  assign w_shr = r_acc >> Dsrin[2:0];

  // Unrolled restoring divider; a zero divisor yields all-ones.
  always_comb begin
    w_rem = 9'd0;
    w_div = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      w_rem = {w_rem[7:0], r_acc[i]};
      if (w_rem >= {1'b0, Dsrin}) begin
        w_rem    = w_rem - {1'b0, Dsrin};
        w_div[i] = 1'b1;
      end
    end
    if (Dsrin == 8'd0) w_div = 8'hFF;
  end

  always_comb begin
    w_next = Dsrin;
    unique case (w_op)
      OP_SUM:  w_next = w_sum;
      OP_SUB:  w_next = w_sub;
      OP_MUL:  w_next = w_mul;
      OP_DIV:  w_next = w_div;
      OP_SHL:  w_next = w_shl;
      OP_SHR:  w_next = w_shr;
      default: w_next = Dsrin;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_acc <= 8'h00;
    else if (!ESRn) r_acc <= w_next;
  end

  assign Dout = r_acc;

endmodule

// File: tb/tb_sr.sv
// tb_sr: directed checks of the sr result register.
// Inputs change 1 time unit after each rising edge; Dout is checked there.
module tb_sr;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn;
  logic       ESRn;
  logic [7:0] Dsrin;
  logic [7:0] Dout;

  int checks = 0;
  int errors = 0;

  sr dut (
    .CLK  (CLK),
    .RST  (RST),
    .ISUMn(ISUMn),
    .ISUBn(ISUBn),
    .IMULn(IMULn),
    .IDIVn(IDIVn),
    .ISHLn(ISHLn),
    .ISHRn(ISHRn),
    .ESRn (ESRn),
    .Dsrin(Dsrin),
    .Dout (Dout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (Dout === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, Dout, exp);
    end
  endtask

  // Strobe arguments are active-high here for readability.
  task automatic ops(input logic sum, input logic sub, input logic mul,
                     input logic div, input logic shl, input logic shr);
    ISUMn = ~sum;
    ISUBn = ~sub;
    IMULn = ~mul;
    IDIVn = ~div;
    ISHLn = ~shl;
    ISHRn = ~shr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    ops(0, 0, 0, 0, 0, 0);
    ESRn  = 1'b0;
    Dsrin = v;
    tick();
  endtask

  initial begin
    RST   = 1'b1;
    ESRn  = 1'b1;
    Dsrin = 8'h00;
    ops(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset", 8'h00);
    tick();
    RST = 1'b0;

    ops(1, 0, 0, 0, 0, 0);
    ESRn  = 1'b1;
    Dsrin = 8'h07;
    tick(); chk("hold_add1", 8'h00);
    tick(); chk("hold_add2", 8'h00);
    ESRn  = 1'b0;
    Dsrin = 8'h04;
    tick(); chk("add1", 8'h04);
    tick(); chk("add2", 8'h08);

    ops(0, 1, 0, 0, 0, 0);
    tick(); chk("sub1", 8'h04);
    tick(); chk("sub2", 8'h00);
    tick(); chk("sub_wrap", 8'hFC);
    ESRn  = 1'b1;
    Dsrin = 8'h09;
    tick(); chk("hold_sub", 8'hFC);

    load(8'h10); chk("load10", 8'h10);
    ops(0, 0, 1, 0, 0, 0);
    Dsrin = 8'h03;
    tick(); chk("mul3", 8'h30);
    Dsrin = 8'h20;
    tick(); chk("mul_trunc", 8'h00);

    load(8'h64); chk("load64", 8'h64);
    ops(0, 0, 0, 1, 0, 0);
    Dsrin = 8'h07;
    tick(); chk("div7", 8'h0E);
    Dsrin = 8'h00;
    tick(); chk("div0", 8'hFF);
    Dsrin = 8'h10;
    tick(); chk("div16", 8'h0F);

    load(8'h81);
    ops(0, 0, 0, 0, 1, 0);
    Dsrin = 8'h01;
    tick(); chk("shl1", 8'h02);
    Dsrin = 8'hFA;
    tick(); chk("shl_hi_ignored", 8'h08);

    load(8'h81);
    ops(0, 0, 0, 0, 0, 1);
    Dsrin = 8'h0B;
    tick(); chk("shr3", 8'h10);

    load(8'h05);
    ops(1, 1, 0, 0, 0, 0);
    Dsrin = 8'h01;
    tick(); chk("prio_add_sub", 8'h06);
    ops(0, 0, 1, 1, 0, 0);
    Dsrin = 8'h02;
    tick(); chk("prio_mul_div", 8'h0C);
    ops(0, 1, 0, 1, 1, 1);
    Dsrin = 8'h03;
    tick(); chk("prio_sub_rest", 8'h09);
    ESRn = 1'b1;
    ops(1, 1, 1, 1, 1, 1);
    Dsrin = 8'h77;
    tick(); chk("hold_all", 8'h09);

    load(8'hAB); chk("loadAB", 8'hAB);
    ESRn = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst", 8'h00);
    ESRn  = 1'b0;
    Dsrin = 8'h55;
    tick(); chk("rst_hold_edge", 8'h00);
    RST = 1'b0;
    ops(1, 0, 0, 0, 0, 0);
    Dsrin = 8'h03;
    tick(); chk("restart_add", 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
